// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel column/row, lock state and sync errors from a VGA hsync/vsync pair.
// Optional sticky-error event counter is built only when VGA_SYNC_DECODER_ERR_COUNT_EN is defined.
module vga_sync_decoder #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_TOTAL  = 525
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       clr_err,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       active,
  output logic       locked,
  output logic       frame_start,
  output logic [7:0] frame_count,
  output logic       h_err,
  output logic       v_err,
  output logic [7:0] err_count
);

  localparam logic [9:0] H_LOAD   = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] V_LOAD   = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [6:0] H_SYNC_W = 7'(H_SYNC);

  // Timings must fit the 10-bit counters and the saturating 7-bit width counter.
  if (H_SYNC < 1 || H_SYNC > 126 || V_SYNC < 1 || V_SYNC >= V_TOTAL ||
      H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_cfg_check
    $error("vga_sync_decoder: timing parameters out of range");
  end

  typedef enum logic [1:0] {
    SEARCH    = 2'd0,
    H_ALIGNED = 2'd1,
    V_ALIGNED = 2'd2,
    LOCKED    = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_hs_q;
  logic       r_vs_q;
  logic [6:0] r_hs_width;
  logic [9:0] r_pixel_x;
  logic [9:0] r_pixel_y;
  logic       r_locked;
  logic       r_frame_start;
  logic [7:0] r_frame_count;
  logic       r_h_err;
  logic       r_v_err;

  logic       w_hs_fall;
  logic       w_hs_rise;
  logic       w_vs_fall;
  logic       w_x_wrap;
  logic [9:0] w_x_inc;
  logic [9:0] w_y_inc;
  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;
  logic       w_h_pos_err;
  logic       w_h_wid_err;
  logic       w_h_err_set;
  logic       w_v_err_set;
  logic       w_frame_start_nxt;

  assign w_hs_fall = r_hs_q & ~hsync;
  assign w_hs_rise = ~r_hs_q & hsync;
  assign w_vs_fall = r_vs_q & ~vsync;
  assign w_x_wrap  = (r_pixel_x == H_LAST);
  assign w_x_inc   = w_x_wrap ? 10'd0 : r_pixel_x + 10'd1;

  // Free-running row advance, used both for counting and for the vsync position check.
  always_comb begin
    w_y_inc = r_pixel_y;
    if (w_x_wrap) begin
      if (r_pixel_y == V_LAST) begin
        w_y_inc = 10'd0;
      end else begin
        w_y_inc = r_pixel_y + 10'd1;
      end
    end else begin
      w_y_inc = r_pixel_y;
    end
  end

  // Sync edges re-align the counters; vsync is ignored until horizontal alignment exists.
  assign w_x_nxt = w_hs_fall ? H_LOAD : w_x_inc;
  assign w_y_nxt = (w_vs_fall && (r_state != SEARCH)) ? V_LOAD : w_y_inc;

  assign w_h_pos_err = w_hs_fall && (r_state != SEARCH) && (w_x_inc != H_LOAD);
  assign w_h_wid_err = w_hs_rise && (r_state != SEARCH) && (r_hs_width != H_SYNC_W);
  assign w_h_err_set = w_h_pos_err | w_h_wid_err;
  assign w_v_err_set = w_vs_fall && (r_state == LOCKED) && (w_y_inc != V_LOAD);

  // Lock acquisition; horizontal errors dominate and always fall back to H_ALIGNED.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SEARCH: begin
        if (w_hs_fall) begin
          w_state_nxt = H_ALIGNED;
        end else begin
          w_state_nxt = SEARCH;
        end
      end
      H_ALIGNED: begin
        if (w_h_err_set) begin
          w_state_nxt = H_ALIGNED;
        end else if (w_vs_fall) begin
          w_state_nxt = V_ALIGNED;
        end else begin
          w_state_nxt = H_ALIGNED;
        end
      end
      V_ALIGNED: begin
        if (w_h_err_set) begin
          w_state_nxt = H_ALIGNED;
        end else if (w_vs_fall && (w_y_inc == V_LOAD)) begin
          w_state_nxt = LOCKED;
        end else begin
          w_state_nxt = V_ALIGNED;
        end
      end
      LOCKED: begin
        if (w_h_err_set) begin
          w_state_nxt = H_ALIGNED;
        end else if (w_v_err_set) begin
          w_state_nxt = V_ALIGNED;
        end else begin
          w_state_nxt = LOCKED;
        end
      end
      default: w_state_nxt = SEARCH;
    endcase
  end

  assign w_frame_start_nxt = (w_x_nxt == 10'd0) && (w_y_nxt == 10'd0) && (w_state_nxt == LOCKED);

  // State, sync history and position counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= SEARCH;
      r_hs_q     <= 1'b1;
      r_vs_q     <= 1'b1;
      r_hs_width <= 7'd0;
      r_pixel_x  <= 10'd0;
      r_pixel_y  <= 10'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_hs_q    <= hsync;
      r_vs_q    <= vsync;
      r_pixel_x <= w_x_nxt;
      r_pixel_y <= w_y_nxt;
      if (w_hs_fall) begin
        r_hs_width <= 7'd1;
      end else if (!hsync && (r_hs_width != 7'd127)) begin
        r_hs_width <= r_hs_width + 7'd1;
      end else begin
        r_hs_width <= r_hs_width;
      end
    end
  end

  // Registered status outputs; a new error beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_locked      <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= 8'd0;
      r_h_err       <= 1'b0;
      r_v_err       <= 1'b0;
    end else begin
      r_locked      <= (w_state_nxt == LOCKED);
      r_frame_start <= w_frame_start_nxt;
      r_frame_count <= r_frame_count + {7'd0, w_frame_start_nxt};
      r_h_err       <= w_h_err_set | (r_h_err & ~clr_err);
      r_v_err       <= w_v_err_set | (r_v_err & ~clr_err);
    end
  end

`ifdef VGA_SYNC_DECODER_ERR_COUNT_EN
  logic [7:0] r_err_count;
  logic       w_err_evt;

  assign w_err_evt = w_h_err_set | w_v_err_set;

  // Saturating count of error events; an event in the clearing cycle counts as the first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_count <= 8'd0;
    end else if (clr_err) begin
      r_err_count <= w_err_evt ? 8'd1 : 8'd0;
    end else if (w_err_evt && (r_err_count != 8'd255)) begin
      r_err_count <= r_err_count + 8'd1;
    end else begin
      r_err_count <= r_err_count;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'd0;
`endif

  assign pixel_x     = r_pixel_x;
  assign pixel_y     = r_pixel_y;
  assign active      = (r_pixel_x < H_ACT) && (r_pixel_y < V_ACT) && r_locked;
  assign locked      = r_locked;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;
  assign h_err       = r_h_err;
  assign v_err       = r_v_err;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder using a scaled-down video timing so whole frames stay short.
module tb_vga_sync_decoder;

  localparam int HA = 16, HF = 4, HS = 8, HT = 40;
  localparam int VA = 12, VF = 2, VS = 2, VT = 20;
  localparam int HLOAD = HA + HF;
  localparam int VLOAD = VA + VF;
`ifdef VGA_SYNC_DECODER_ERR_COUNT_EN
  localparam int EC_SAT = 255;
`else
  localparam int EC_SAT = 0;
`endif

  localparam int S_PX = 0, S_PY = 1, S_ACT = 2, S_LOCK = 3, S_FS = 4;
  localparam int S_FC = 5, S_HE = 6, S_VE = 7, S_EC = 8, S_FSN = 9;

  logic       clk = 1'b0;
  logic       reset_n, hsync, vsync, clr_err;
  logic [9:0] pixel_x, pixel_y;
  logic       active, locked, frame_start, h_err, v_err;
  logic [7:0] frame_count, err_count;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync), .clr_err(clr_err),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .active(active), .locked(locked),
    .frame_start(frame_start), .frame_count(frame_count),
    .h_err(h_err), .v_err(v_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          sig;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   fs_seen = 0;

  // Source generator state: current column/row and injected timing faults.
  int gx, gy, last_x, last_y;
  int hw = HS;
  int vfall = VLOAD;
  int skip_line = -1, skip_from = -1, skip_to = 0;

  function automatic logic [31:0] get_sig(int s);
    case (s)
      S_PX:    return {22'd0, pixel_x};
      S_PY:    return {22'd0, pixel_y};
      S_ACT:   return {31'd0, active};
      S_LOCK:  return {31'd0, locked};
      S_FS:    return {31'd0, frame_start};
      S_FC:    return {24'd0, frame_count};
      S_HE:    return {31'd0, h_err};
      S_VE:    return {31'd0, v_err};
      S_EC:    return {24'd0, err_count};
      S_FSN:   return fs_seen;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic expect_now(string nm, int s, int e);
    chk_t c;
    c.due  = cyc;
    c.sig  = s;
    c.exp  = e;
    c.name = nm;
    sb.push_back(c);
  endtask

  // Monitor: retire every expectation that has come due, away from the active edge.
  always @(negedge clk) begin : mon
    chk_t        c;
    logic [31:0] a;
    if (frame_start === 1'b1) fs_seen++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      c = sb.pop_front();
      a = get_sig(c.sig);
      n_vec++;
      if (a !== c.exp) begin
        n_err++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", c.name, a, c.exp, cyc);
      end
    end
  end

  task automatic tick_col();
    if (gy == skip_line && gx == skip_from) begin
      gx = skip_to;
      skip_line = -1;
    end
    hsync = (gx >= HLOAD && gx < HLOAD + hw) ? 1'b0 : 1'b1;
    vsync = (gy >= vfall && gy < vfall + VS) ? 1'b0 : 1'b1;
    @(posedge clk);
    #1;
    last_x = gx;
    last_y = gy;
    if (gx == HT - 1) begin
      gx = 0;
      gy = (gy == VT - 1) ? 0 : gy + 1;
    end else begin
      gx++;
    end
  endtask

  task automatic run_to(int x, int y);
    int n = 0;
    do begin
      tick_col();
      n++;
    end while (!(last_x == x && last_y == y) && n < 2 * HT * VT);
    n_vec++;
    if (!(last_x == x && last_y == y)) begin
      n_err++;
      $display("FAIL run_to: got (%0d,%0d) expected (%0d,%0d) within %0d cycles", last_x, last_y, x, y, n);
    end
  endtask

  task automatic clr_tick();
    clr_err = 1'b1;
    tick_col();
    clr_err = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; hsync = 1'b1; vsync = 1'b1; clr_err = 1'b0;
    gx = 0; gy = 0; last_x = -1; last_y = -1;
    repeat (3) @(posedge clk);
    #1;
    expect_now("rst_px", S_PX, 0);     expect_now("rst_py", S_PY, 0);
    expect_now("rst_lock", S_LOCK, 0); expect_now("rst_fs", S_FS, 0);
    expect_now("rst_fc", S_FC, 0);     expect_now("rst_he", S_HE, 0);
    expect_now("rst_ve", S_VE, 0);     expect_now("rst_ec", S_EC, 0);
    expect_now("rst_act", S_ACT, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Nominal acquisition over three frames.
    run_to(HLOAD, 0);
    expect_now("acq_px", S_PX, HLOAD); expect_now("acq_lock0", S_LOCK, 0); expect_now("acq_he", S_HE, 0);
    run_to(0, VLOAD);
    expect_now("v1_px", S_PX, 0); expect_now("v1_py", S_PY, VLOAD); expect_now("v1_lock", S_LOCK, 0);
    run_to(0, VLOAD);
    expect_now("v2_lock", S_LOCK, 1); expect_now("v2_py", S_PY, VLOAD);
    run_to(0, 0);
    expect_now("f3_fs", S_FS, 1); expect_now("f3_fc", S_FC, 1); expect_now("f3_act", S_ACT, 1);
    expect_now("f3_px", S_PX, 0); expect_now("f3_py", S_PY, 0);
    tick_col();
    expect_now("f3_fs_off", S_FS, 0); expect_now("f3_fc_hold", S_FC, 1);
    run_to(HA - 1, VA - 1);
    expect_now("act_corner", S_ACT, 1);
    tick_col();
    expect_now("act_xedge", S_ACT, 0);
    run_to(0, VA);
    expect_now("act_yedge", S_ACT, 0);
    run_to(HT - 1, VT - 1);
    expect_now("nom_fc", S_FC, 1); expect_now("nom_he", S_HE, 0); expect_now("nom_ve", S_VE, 0);
    expect_now("nom_ec", S_EC, 0); expect_now("nom_fs_cnt", S_FSN, 1);

    // hsync falling four columns early.
    skip_line = 2; skip_from = HA; skip_to = HLOAD;
    run_to(HLOAD, 2);
    expect_now("early_he", S_HE, 1); expect_now("early_px", S_PX, HLOAD); expect_now("early_lock", S_LOCK, 0);
    run_to(0, VLOAD);
    expect_now("early_v1_lock", S_LOCK, 0);
    run_to(0, VLOAD);
    expect_now("early_relock", S_LOCK, 1); expect_now("early_he_sticky", S_HE, 1);
    clr_tick();
    expect_now("early_clr", S_HE, 0);

    // hsync pulse one cycle short.
    run_to(HT - 1, VLOAD + 1);
    hw = HS - 1;
    run_to(HLOAD + HS - 2, VLOAD + 2);
    expect_now("short_pre_he", S_HE, 0); expect_now("short_pre_lock", S_LOCK, 1);
    tick_col();
    expect_now("short_he", S_HE, 1); expect_now("short_lock", S_LOCK, 0);
    hw = HS;
    run_to(0, VLOAD);
    run_to(0, VLOAD);
    expect_now("short_relock", S_LOCK, 1);
    clr_tick();

    // vsync falling on an unexpected line.
    vfall = 9;
    run_to(0, 9);
    expect_now("vbad_ve", S_VE, 1); expect_now("vbad_py", S_PY, VLOAD);
    expect_now("vbad_lock", S_LOCK, 0); expect_now("vbad_he", S_HE, 0);
    gy = VLOAD; vfall = VLOAD;

    // clr_err coinciding with a new horizontal error.
    skip_line = VLOAD + 2; skip_from = HA; skip_to = HLOAD;
    run_to(HA - 1, VLOAD + 2);
    clr_tick();
    expect_now("clr_new_he", S_HE, 1); expect_now("clr_old_ve", S_VE, 0); expect_now("clr_px", S_PX, HLOAD);
    run_to(0, VLOAD);
    run_to(0, VLOAD);
    expect_now("clr_relock", S_LOCK, 1);

    // Horizontal and vertical errors together, with clr_err asserted.
    vfall = 9; skip_line = 9; skip_from = 0; skip_to = HLOAD;
    run_to(HT - 1, 8);
    clr_tick();
    expect_now("both_he", S_HE, 1); expect_now("both_ve", S_VE, 1); expect_now("both_px", S_PX, HLOAD);
    expect_now("both_py", S_PY, VLOAD); expect_now("both_lock", S_LOCK, 0);
    gy = VLOAD; vfall = VLOAD;
    run_to(0, VLOAD);
    expect_now("both_v1_lock", S_LOCK, 0);
    run_to(0, VLOAD);
    expect_now("both_relock", S_LOCK, 1);
    clr_tick();
    expect_now("both_clr_he", S_HE, 0); expect_now("both_clr_ve", S_VE, 0);

    // Reset pulse mid-frame with hsync held low through release.
    reset_n = 1'b0; hsync = 1'b0; vsync = 1'b1;
    expect_now("mrst_px", S_PX, 0); expect_now("mrst_py", S_PY, 0); expect_now("mrst_lock", S_LOCK, 0);
    expect_now("mrst_fc", S_FC, 0); expect_now("mrst_act", S_ACT, 0); expect_now("mrst_fs", S_FS, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    expect_now("rel_px", S_PX, HLOAD); expect_now("rel_py", S_PY, 0); expect_now("rel_lock", S_LOCK, 0);

    // Error burst: rapid hsync toggling.
    for (int i = 0; i < 400; i++) begin
      hsync = ((i % 2) == 0) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
    end
    hsync = 1'b1;
    expect_now("burst_ec", S_EC, EC_SAT); expect_now("burst_he", S_HE, 1); expect_now("burst_lock", S_LOCK, 0);

    repeat (4) @(posedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640, H_FRONT 16, H_SYNC 96, H_TOTAL 800, V_ACTIVE 480, V_FRONT 10, V_SYNC 2, V_TOTAL 525 (pixel/line counts, 640x480@60, 25 MHz).
REQ-002 SHALL have ports: clk in 1, system clock, one pixel per cycle; reset_n in 1, reset, asynchronous, active-low.
REQ-003 SHALL have ports: hsync in 1, active-low horizontal sync; vsync in 1, active-low vertical sync; clr_err in 1, synchronous clear of sticky errors.
REQ-004 SHALL have outputs: pixel_x out 10, recovered column; pixel_y out 10, recovered row; active out 1, pixel_x<H_ACTIVE and pixel_y<V_ACTIVE and locked.
REQ-005 SHALL have outputs: locked out 1; frame_start out 1, one-cycle pulse; frame_count out 8; h_err out 1, sticky; v_err out 1, sticky; err_count out 8.

Function
REQ-006 SHALL register hsync/vsync once (hs_q, vs_q); a falling edge is hs_q=1 and hsync=0, evaluated each cycle.
REQ-007 SHALL have 1-cycle latency: after the edge that samples the first low hsync, pixel_x=H_ACTIVE+H_FRONT (656).
REQ-008 SHALL free-run pixel_x +1 per cycle, wrapping H_TOTAL-1 -> 0; pixel_y SHALL +1 on each pixel_x wrap, wrapping V_TOTAL-1 -> 0.
REQ-009 SHALL load pixel_y=V_ACTIVE+V_FRONT (490) on a vsync falling edge; if it coincides with a pixel_x wrap, the load wins.
REQ-010 SHALL use FSM states SEARCH, H_ALIGNED, V_ALIGNED, LOCKED; locked=1 only in LOCKED.
REQ-011 SEARCH: hsync fall -> H_ALIGNED (pixel_x loaded); vsync edges are ignored.
REQ-012 H_ALIGNED: vsync fall -> V_ALIGNED (pixel_y loaded).
REQ-013 V_ALIGNED: vsync fall at expected position (pixel_y would become 490 without a load) -> LOCKED; a mismatch stays in V_ALIGNED and reloads.
REQ-014 An hsync fall in any state except SEARCH where the next pixel_x would not be 656 SHALL set h_err, reload pixel_x, and go to H_ALIGNED.
REQ-015 An hsync low width not equal to H_SYNC cycles, measured by a 7-bit width counter saturating at 127, SHALL set h_err, and H_ALIGNED/V_ALIGNED/LOCKED -> H_ALIGNED.
REQ-016 In LOCKED, a vsync fall at an unexpected pixel_y SHALL set v_err, reload pixel_y, and go to V_ALIGNED.
REQ-017 When h_err and v_err conditions occur in the same cycle, both flags SHALL set and the next state SHALL be H_ALIGNED.
REQ-018 frame_start SHALL pulse in the cycle pixel_x=0 and pixel_y=0 while locked; frame_count SHALL increment on frame_start and wrap 255 -> 0.
REQ-019 clr_err SHALL clear h_err/v_err next cycle; a new error in the same cycle SHALL take priority, leaving the flag set.
REQ-020 Outputs SHALL be registered; active SHALL be decoded from registered counters and locked.

Reset
REQ-021 SHALL, while reset_n=0, asynchronously force state=SEARCH, pixel_x=0, pixel_y=0, frame_count=0, err_count=0, and all flags/pulses=0.
REQ-022 SHALL force hs_q and vs_q to 1, so an input already low at release is detected as an edge on the first clock.
REQ-023 Reset assertion mid-frame SHALL discard lock; reacquisition requires REQ-011..013 anew.

Configuration
REQ-024 With macro VGA_SYNC_DECODER_ERR_COUNT_EN defined, err_count SHALL increment (saturating at 255) on every cycle where h_err or v_err is newly set, and clear on clr_err.
REQ-025 Without VGA_SYNC_DECODER_ERR_COUNT_EN, err_count SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-026 Nominal 640x480 source, 3 frames after reset -> locked=1 at the second vsync fall, frame_start 1 pulse/frame, frame_count=1 after third frame, h_err=v_err=0.
REQ-027 Locked; one hsync fall 4 cycles early -> h_err=1, state H_ALIGNED, pixel_x=656 next cycle, relock after two further good vsyncs.
REQ-028 Locked; hsync low 95 cycles -> h_err=1 at rising edge, locked=0.
REQ-029 Locked; vsync fall at line 300 -> v_err=1, pixel_y=490, locked=0; clr_err and new error in same cycle -> h_err/v_err stays 1.
REQ-030 hsync held low through reset release -> pixel_x=656 one cycle after first clock; reset_n pulsed mid-frame -> all outputs 0 immediately.
REQ-031 ERR_COUNT_EN defined, 300 injected errors -> err_count=255; undefined -> err_count=0 throughout.
